load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the ALU in the execute path. It consumes the ALU result as the effective address, performs byte/halfword/word loads and stores over a simple req/ack data-memory bus, and returns sign- or zero-extended load data for register writeback. It stalls the datapath via `busy` until the access completes, faults or times out.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles without `mem_ack` before a bus error; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in 1: memory instruction present; held by datapath until `done`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- `req_addr` in 32: effective address (ALU Result).
- `req_wdata` in 32: store data (rs2).
- `busy` out 1: stall PC/writeback.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load data, valid with `done`, held until next `done`.
- `misaligned` out 1: alignment fault, pulses with `done`.
- `bus_err` out 1: illegal funct3 or timeout, pulses with `done`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32 (bits [1:0] = 0), `mem_wdata` out 32, `mem_be` out 4: memory request.
- `mem_ack` in 1, `mem_rdata` in 32: memory response.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: on `req_valid`, decode. Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0) or illegal funct3 (load 011/110/111; store 1xx or 011) -> DONE with fault flag latched, no bus access. Otherwise latch address/data/control -> ACCESS.
- ACCESS: `mem_req`=1, all `mem_*` outputs stable. Cycle with `mem_ack`=1: capture `mem_rdata`, -> DONE. Timeout counter increments each ACCESS cycle without ack; reaching TIMEOUT_CYCLES -> DONE with `bus_err`, `mem_req` drops, `rdata`=0.
- DONE: `done`=1 for exactly one cycle plus latched flags; `req_valid` ignored; -> IDLE.
- `busy` = `req_valid` & ~`done` (combinational), so PC freezes the cycle the request appears.
- Lane = addr[1:0]. Store: SB `mem_wdata`={4{b}}, `mem_be`=0001<<lane; SH {2{h}}, 0011<<lane; SW word, 1111. Load: extract byte/half at lane from `mem_rdata`; B/H sign-extend, BU/HU zero-extend, W as-is. Loads drive `mem_be`=1111.
- Faulted ops: `rdata` = 0; no write ever reaches memory.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- Reset values: state IDLE; `done`, `misaligned`, `bus_err`, `mem_req`, `mem_we` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0; `mem_be` = 0; timeout counter = 0.
- `rst` mid-ACCESS: `mem_req` low at next edge, no `done`; memory must tolerate abandoned request.
- Latency from `req_valid` (cycle 0): ack in cycle 1 -> `done` cycle 2; ack in cycle k -> `done` cycle k+1; fault -> `done` cycle 1; timeout -> `done` cycle TIMEOUT_CYCLES+1.
- Back-to-back ops: next request sampled no earlier than the cycle after `done`.
- All non-`busy` outputs registered.

## Structure
- Shared package `riscv_pkg`: funct3 load/store localparams, FSM state enum, `mem_be` encodings.
- Sub-module `lsu_align`: combinational store lane steering/byte-enable generation and load extraction/extension; FSM, timeout counter and registers live in `load_store_unit`.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ack cycle 1 -> `mem_addr`=0x100, `mem_be`=1111, `done` cycle 2, `busy` high cycles 0-1.
- LB addr 0x103, `mem_rdata`=0x80FF_FF00 -> `rdata`=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SH addr 0x102, data 0x1234_ABCD -> `mem_wdata`=0xABCDABCD, `mem_be`=1100.
- LW addr 0x101 -> `misaligned`+`done` cycle 1, `mem_req` never asserted, `rdata`=0.
- LW with `mem_ack` never asserted, TIMEOUT_CYCLES=4 -> `bus_err`+`done` cycle 5, `mem_req` low from cycle 5; funct3=111 load -> `bus_err` cycle 1.
- `rst` asserted in ACCESS cycle 2 with ack pending -> `mem_req`=0 cycle 3, no `done`; following LW completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the execute-path load/store unit.
//   - RV32I funct3 encodings for loads and stores
//   - LSU FSM state enum
//   - Base byte-enable patterns (shifted to the addressed lane)
//   - funct3 legality / alignment helper functions
// -----------------------------------------------------------------------------
package riscv_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte-enable patterns at lane 0
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } lsu_state_e;

  // Legal loads: B, H, W, BU, HU. Legal stores: B, H, W.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end
    return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

  // Size is carried by funct3[1:0] for both loads and stores.
  function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b01:   return lane[0];
      2'b10:   return (lane != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the load/store unit.
//   funct3     in  3  : access size / signedness
//   lane       in  2  : address bits [1:0]
//   wdata      in  32 : store data (rs2)
//   mem_rdata  in  32 : raw word returned by memory
//   store_data out 32 : store data replicated across all lanes
//   store_be   out 4  : byte enables for the addressed lane(s)
//   load_data  out 32 : extracted and sign/zero-extended load data
// -----------------------------------------------------------------------------
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] store_data,
  output logic [3:0]  store_be,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Replicating the datum means the memory only needs byte enables to
  // place it; no barrel shifter is needed on the write path.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path through the case can leave it unassigned and infer a latch.
    store_data = wdata;
    store_be   = BE_WORD;
    case (funct3[1:0])
      2'b00: begin
        store_data = {4{wdata[7:0]}};
        store_be   = BE_BYTE << lane;
      end
      2'b01: begin
        store_data = {2{wdata[15:0]}};
        store_be   = BE_HALF << lane;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (lane)
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      2'd3:    lane_byte = mem_rdata[31:24];
      default: ;
    endcase
    lane_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_data = mem_rdata;
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LBU:  load_data = {24'h0, lane_byte};
      F3_LHU:  load_data = {16'h0, lane_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle load/store unit fed by the ALU result as effective address.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/we/funct3/addr/wdata : memory instruction from the datapath
//   busy                     : combinational stall (req_valid & ~done)
//   done                     : one-cycle completion pulse
//   rdata                    : extended load data, held until the next done
//   misaligned, bus_err      : fault flags, pulse with done
//   mem_req/we/addr/wdata/be : registered memory request
//   mem_ack, mem_rdata       : memory response
// -----------------------------------------------------------------------------
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state;
  logic [7:0]  tcount;
  logic [2:0]  op_funct3;
  logic [1:0]  op_lane;
  logic        op_we;

  logic [2:0]  align_funct3;
  logic [1:0]  align_lane;
  logic [31:0] store_data;
  logic [3:0]  store_be;
  logic [31:0] load_data;

  // One aligner serves both phases: in IDLE it steers the incoming store,
  // in ACCESS it extracts the load using the latched control.
  assign align_funct3 = (state == ST_IDLE) ? req_funct3    : op_funct3;
  assign align_lane   = (state == ST_IDLE) ? req_addr[1:0] : op_lane;

  lsu_align u_align (
    .funct3     (align_funct3),
    .lane       (align_lane),
    .wdata      (req_wdata),
    .mem_rdata  (mem_rdata),
    .store_data (store_data),
    .store_be   (store_be),
    .load_data  (load_data)
  );

  assign busy = req_valid & ~done;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tcount     <= '0;
      op_funct3  <= '0;
      op_lane    <= '0;
      op_we      <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      rdata      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= BE_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (!funct3_legal(req_we, req_funct3)) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              bus_err <= 1'b1;
              rdata   <= '0;
            end else if (addr_misaligned(req_funct3, req_addr[1:0])) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
              rdata      <= '0;
            end else begin
              state     <= ST_ACCESS;
              tcount    <= '0;
              op_funct3 <= req_funct3;
              op_lane   <= req_addr[1:0];
              op_we     <= req_we;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_we ? store_data : '0;
              mem_be    <= req_we ? store_be : BE_WORD;
            end
          end
        end

        ST_ACCESS: begin
          if (mem_ack) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            tcount  <= '0;
            if (!op_we) rdata <= load_data;
          end else if (tcount == TIMEOUT_LAST) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            bus_err <= 1'b1;
            rdata   <= '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            tcount  <= '0;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end

        ST_DONE: begin
          state      <= ST_IDLE;
          done       <= 1'b0;
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed vectors with hand-computed expectations for load_store_unit.
// Cycle 0 is the cycle in which req_valid is first presented; outputs are
// sampled on the falling edge of each cycle.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  // Observations from the most recent run_op
  int          done_cyc;
  int          first_req;
  int          last_req;
  int          busy_cnt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [31:0] res_rdata;
  logic        res_mis;
  logic        res_err;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request (called just after a rising edge). ack_cyc < 0 means
  // memory never acknowledges. Returns with req_valid low, one idle cycle on.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] resp, input int ack_cyc);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    done_cyc   = -1;
    first_req  = -1;
    last_req   = -1;
    busy_cnt   = 0;
    cap_addr   = '0;
    cap_wdata  = '0;
    cap_be     = '0;
    cap_we     = 1'b0;
    res_rdata  = '0;
    res_mis    = 1'b0;
    res_err    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      mem_ack   = (c == ack_cyc);
      mem_rdata = resp;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mem_req) begin
        if (first_req < 0) begin
          first_req = c;
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
          cap_be    = mem_be;
          cap_we    = mem_we;
        end
        last_req = c;
      end
      if (done) begin
        done_cyc  = c;
        res_rdata = rdata;
        res_mis   = misaligned;
        res_err   = bus_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_done",     32'(done),       32'h0);
    check("rst_busy",     32'(busy),       32'h0);
    check("rst_mem_req",  32'(mem_req),    32'h0);
    check("rst_mem_be",   32'(mem_be),     32'h0);
    check("rst_rdata",    rdata,           32'h0);
    check("rst_mem_addr", mem_addr,        32'h0);
    check("rst_flags",    32'({misaligned, bus_err, mem_we}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Stray ack with no request outstanding must be ignored
    mem_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_done", 32'(done),    32'h0);
    check("stray_ack_req",  32'(mem_req), 32'h0);
    @(posedge clk); #1;

    // SW 0x100
    run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    check("sw_done_cyc", 32'(done_cyc),  32'd2);
    check("sw_req_cyc",  32'(first_req), 32'd1);
    check("sw_addr",     cap_addr,       32'h100);
    check("sw_be",       32'(cap_be),    32'hF);
    check("sw_wdata",    cap_wdata,      32'hDEADBEEF);
    check("sw_we",       32'(cap_we),    32'h1);
    check("sw_busy_cnt", 32'(busy_cnt),  32'd2);
    check("sw_flags",    32'({res_mis, res_err}), 32'h0);

    // Byte/half loads from 0x80FF_FF00
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF00, 1);
    check("lb_rdata",    res_rdata,      32'hFFFFFF80);
    check("lb_addr",     cap_addr,       32'h100);
    check("lb_be",       32'(cap_be),    32'hF);
    check("lb_we",       32'(cap_we),    32'h0);
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF00, 1);
    check("lbu_rdata",   res_rdata,      32'h00000080);
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FFFF00, 1);
    check("lhu_rdata",   res_rdata,      32'h000080FF);
    run_op(1'b0, 3'b001, 32'h100, 32'h0, 32'h00008001, 1);
    check("lh_rdata",    res_rdata,      32'hFFFF8001);

    // SH 0x102, ack in cycle 3 -> done cycle 4
    run_op(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 3);
    check("sh_wdata",    cap_wdata,      32'hABCDABCD);
    check("sh_be",       32'(cap_be),    32'hC);
    check("sh_done_cyc", 32'(done_cyc),  32'd4);

    // SB 0x101
    run_op(1'b1, 3'b000, 32'h101, 32'h00000077, 32'h0, 1);
    check("sb_wdata",    cap_wdata,      32'h77777777);
    check("sb_be",       32'(cap_be),    32'h2);

    // LW misaligned: rdata was 0x80FF from LHU... now LH left 0xFFFF8001
    run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
    check("lw_mis_done_cyc", 32'(done_cyc),  32'd1);
    check("lw_mis_flag",     32'(res_mis),   32'h1);
    check("lw_mis_err",      32'(res_err),   32'h0);
    check("lw_mis_no_req",   32'(first_req), 32'hFFFFFFFF);
    check("lw_mis_rdata",    res_rdata,      32'h0);

    // SH misaligned must never reach memory
    run_op(1'b1, 3'b001, 32'h103, 32'h5555AAAA, 32'h0, 1);
    check("sh_mis_flag",   32'(res_mis),   32'h1);
    check("sh_mis_no_req", 32'(first_req), 32'hFFFFFFFF);

    // Good LW, ack cycle 2 -> done cycle 3
    run_op(1'b0, 3'b010, 32'h200, 32'h0, 32'h13579BDF, 2);
    check("lw_done_cyc", 32'(done_cyc),  32'd3);
    check("lw_rdata",    res_rdata,      32'h13579BDF);
    check("lw_addr",     cap_addr,       32'h200);

    // LW timeout with TIMEOUT_CYCLES=4
    run_op(1'b0, 3'b010, 32'h204, 32'h0, 32'hFFFFFFFF, -1);
    check("to_done_cyc", 32'(done_cyc),  32'd5);
    check("to_err",      32'(res_err),   32'h1);
    check("to_mis",      32'(res_mis),   32'h0);
    check("to_last_req", 32'(last_req),  32'd4);
    check("to_rdata",    res_rdata,      32'h0);

    // Illegal funct3
    run_op(1'b0, 3'b111, 32'h300, 32'h0, 32'h0, 1);
    check("ill_ld_done_cyc", 32'(done_cyc),  32'd1);
    check("ill_ld_err",      32'(res_err),   32'h1);
    check("ill_ld_no_req",   32'(first_req), 32'hFFFFFFFF);
    run_op(1'b1, 3'b100, 32'h300, 32'h0, 32'h0, 1);
    check("ill_st_err",      32'(res_err),   32'h1);
    check("ill_st_no_req",   32'(first_req), 32'hFFFFFFFF);

    // Reset in ACCESS cycle 2 with the ack still pending
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h300;
    @(posedge clk); #1;           // cycle 1
    @(posedge clk); #1;           // cycle 2
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req_c2", 32'(mem_req), 32'h1);
    @(posedge clk); #1;           // cycle 3
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_req_c3",  32'(mem_req), 32'h0);
    check("rst_mid_done_c3", 32'(done),    32'h0);
    @(posedge clk); #1;
    run_op(1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 1);
    check("post_rst_done_cyc", 32'(done_cyc), 32'd2);
    check("post_rst_rdata",    res_rdata,     32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
